// File: rtl/if_fetch_queue.sv
// if_fetch_queue: DEPTH-entry {PC, instruction} FIFO between IF and ID.
// Generalises the IF/ID register; Flush empties it, out_ready low freezes it.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   Flush               discard all entries (redirect)
//   in_valid, in_ready  IF side handshake
//   PC_in, instruction_in  fetched pair
//   out_valid, out_ready   ID side handshake (out_ready low = freeze)
//   PC_out, instruction_out  head pair, zero when nothing valid
//   count               occupied entries, 0..DEPTH
//
// Build option: IF_QUEUE_BYPASS_EN gives a same-cycle path from the
// input pair to the outputs when the queue is empty.
module if_fetch_queue #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Flush,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            PC_in,
  input  logic [INSTR_W-1:0]         instruction_in,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            PC_out,
  output logic [INSTR_W-1:0]         instruction_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PC_W-1:0]    pc_mem  [DEPTH];
  logic [INSTR_W-1:0] ins_mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic empty;
  logic push;
  logic wr_en;
  logic rd_en;
  logic byp;

  assign empty    = (count == '0);
  // Depends only on registered count and Flush, never on out_ready.
  assign in_ready = (count != FULL_CNT) && !Flush;
  assign push     = in_valid && in_ready;

`ifdef IF_QUEUE_BYPASS_EN
  assign byp       = empty && in_valid && !Flush;
  assign out_valid = !empty || byp;
  // A bypassed pair taken by ID the same cycle never touches storage.
  assign wr_en     = push && !(byp && out_ready);
`else
  assign byp       = 1'b0;
  assign out_valid = !empty;
  assign wr_en     = push;
`endif

  assign rd_en = !empty && out_ready;

  always_comb begin
    PC_out          = '0;
    instruction_out = '0;
    unique case (1'b1)
      !empty: begin
        PC_out          = pc_mem[rd_ptr];
        instruction_out = ins_mem[rd_ptr];
      end
      byp: begin
        PC_out          = PC_in;
        instruction_out = instruction_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && !Flush) begin
      pc_mem[wr_ptr]  <= PC_in;
      ins_mem[wr_ptr] <= instruction_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: scoreboard bench for if_fetch_queue.
// Directed scenarios followed by randomized traffic against a queue model.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        Flush;
  logic        in_valid;
  logic [31:0] PC_in;
  logic [31:0] instruction_in;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] PC_out;
  logic [31:0] instruction_out;
  logic [2:0]  count;

  if_fetch_queue #(.INSTR_W(32), .PC_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .Flush(Flush),
    .in_valid(in_valid), .PC_in(PC_in),
    .instruction_in(instruction_in), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .PC_out(PC_out), .instruction_out(instruction_out),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } pair_t;

  pair_t sb[$];
  pair_t pend_p;
  bit    pend;
  bit    byp_now;
  bit    last_fl;
  bit    mon_en;
  int    checks;
  int    errors;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Apply the effect of the previous clock edge to the model.
  task automatic commit();
    if (last_fl) begin
      sb.delete();
      pend = 0;
    end else if (pend) begin
      sb.push_back(pend_p);
      pend = 0;
    end
    byp_now = 0;
    last_fl = 0;
  endtask

  task automatic drive(bit v, logic [31:0] pc, logic [31:0] ins,
                       bit ordy, bit fl);
    int occ;
    pair_t p;
    commit();
    in_valid = v;
    PC_in = pc;
    instruction_in = ins;
    out_ready = ordy;
    Flush = fl;
    last_fl = fl;
    occ = sb.size();
    p.pc = pc;
    p.ins = ins;
    if (v && !fl && occ < DEPTH) begin
`ifdef IF_QUEUE_BYPASS_EN
      if (occ == 0) begin
        sb.push_back(p);
        byp_now = 1;
      end else begin
        pend = 1;
        pend_p = p;
      end
`else
      pend = 1;
      pend_p = p;
`endif
    end
  endtask

  task automatic step(bit v, logic [31:0] pc, logic [31:0] ins,
                      bit ordy, bit fl);
    @(posedge clk);
    #1;
    drive(v, pc, ins, ordy, fl);
  endtask

  // Monitor: compares visible DUT state with the model every cycle.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      int ec;
      ec = sb.size() - (byp_now ? 1 : 0);
      chk("count", 64'(count), 64'(ec));
      chk("in_ready", 64'(in_ready), 64'(ec < DEPTH && !Flush));
      chk("out_valid", 64'(out_valid), 64'(sb.size() > 0));
      if (sb.size() > 0) begin
        chk("PC_out", 64'(PC_out), 64'(sb[0].pc));
        chk("instruction_out", 64'(instruction_out), 64'(sb[0].ins));
        if (out_ready && !Flush) void'(sb.pop_front());
      end else begin
        chk("PC_out_zero", 64'(PC_out), 64'd0);
        chk("instr_out_zero", 64'(instruction_out), 64'd0);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    pend = 0;
    byp_now = 0;
    last_fl = 0;
    mon_en = 0;
    rst = 1;
    Flush = 0;
    in_valid = 0;
    PC_in = '0;
    instruction_in = '0;
    out_ready = 0;
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_PC_out", 64'(PC_out), 64'd0);
    chk("rst_instr_out", 64'(instruction_out), 64'd0);
    @(negedge clk);
    rst = 0;
    mon_en = 1;

    // Mid-cycle reset with three entries held.
    for (int i = 1; i <= 3; i++) step(1, 32'(4*i), $urandom, 0, 0);
    step(0, 0, 0, 0, 0);
    #2;
    chk("pre_rst_count", 64'(count), 64'd3);
    rst = 1;
    sb.delete();
    pend = 0;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_PC_out", 64'(PC_out), 64'd0);
    chk("mid_rst_instr_out", 64'(instruction_out), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 0;

    // Fill to full under freeze, then drain.
    for (int i = 1; i <= 4; i++) step(1, 32'(4*i), $urandom, 0, 0);
    step(0, 0, 0, 0, 0);
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);

    // Streaming across two pointer wraps.
    for (int i = 1; i <= 10; i++) step(1, 32'(4*i), $urandom, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Full with pop: push refused this cycle, accepted the next.
    for (int i = 1; i <= 4; i++) step(1, 32'(16*i), $urandom, 0, 0);
    step(1, 32'h500, 32'h11, 1, 0);
    step(1, 32'h500, 32'h11, 0, 0);
    step(0, 0, 0, 0, 0);
    #1;
    chk("full_pop_count", 64'(count), 64'd4);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);

    // Flush with a concurrent fetch at 0x100.
    step(1, 32'h40, 32'h1, 0, 0);
    step(1, 32'h44, 32'h2, 0, 0);
    step(1, 32'h100, 32'h3, 0, 1);
    step(0, 0, 0, 1, 0);
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    step(0, 0, 0, 1, 0);

    // Empty-queue latency for a single instruction.
    step(1, 32'h200, 32'hE3A01005, 1, 0);
    #1;
`ifdef IF_QUEUE_BYPASS_EN
    chk("byp_instr_same", 64'(instruction_out), 64'hE3A01005);
`else
    chk("nobyp_instr_same", 64'(instruction_out), 64'd0);
`endif
    step(0, 0, 0, 1, 0);
    #1;
`ifdef IF_QUEUE_BYPASS_EN
    chk("byp_count", 64'(count), 64'd0);
`else
    chk("nobyp_instr_next", 64'(instruction_out), 64'hE3A01005);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("final_out_valid", 64'(out_valid), 64'd0);
    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
